// File: rtl/serial_burst_master.sv
// Serial bus burst master: arbitrates for the bus, shifts a parallel header, then streams write or read beats.
// Optional stall watchdog is compiled in with SERIAL_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a host request
// REQ    | requesting the bus from the arbiter
// HDR    | shifting slave select, address and burst count
// WLOAD  | waiting for the host's next write beat
// WSHIFT | shifting one write beat out on tx_data
// RSHIFT | collecting read bits from rx_data
// DONE   | one-cycle end-of-transaction pulse
module serial_burst_master #(
  parameter int SLAVE_LEN      = 2,
  parameter int ADDR_LEN       = 12,
  parameter int DATA_LEN       = 8,
  parameter int BURST_LEN      = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [SLAVE_LEN-1:0] req_slave,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [BURST_LEN-1:0] req_burst,
  input  logic [DATA_LEN-1:0]  wdata,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  output logic [DATA_LEN-1:0]  rdata,
  output logic                 rdata_valid,
  output logic                 busy,
  output logic                 err,
  input  logic                 bus_busy,
  input  logic                 approval_grant,
  output logic                 approval_request,
  output logic                 trans_done,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_burst_num,
  output logic                 tx_data,
  input  logic                 rx_data,
  output logic                 master_valid,
  output logic                 master_ready,
  input  logic                 slave_valid,
  input  logic                 slave_ready,
  output logic                 write_en,
  output logic                 read_en
);

  localparam int HDR_LEN = (SLAVE_LEN > ADDR_LEN)
                         ? ((SLAVE_LEN > BURST_LEN) ? SLAVE_LEN : BURST_LEN)
                         : ((ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN);
  localparam int HDR_CW  = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
  localparam int DATA_CW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_HDR    = 3'd2;
  localparam logic [2:0] ST_WLOAD  = 3'd3;
  localparam logic [2:0] ST_WSHIFT = 3'd4;
  localparam logic [2:0] ST_RSHIFT = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]           state;
  logic                 wr_q;
  logic [SLAVE_LEN-1:0] slave_sh;
  logic [ADDR_LEN-1:0]  addr_sh;
  logic [BURST_LEN-1:0] burst_sh;
  logic [BURST_LEN-1:0] beats_left;
  logic [HDR_CW-1:0]    hdr_cnt;
  logic [DATA_CW-1:0]   bit_cnt;
  logic [DATA_LEN-1:0]  data_sh;
  logic [DATA_LEN-1:0]  rx_next;
  logic [DATA_LEN-1:0]  rdata_q;
  logic                 rdata_valid_q;
  logic                 abort;

  assign rx_next = {rx_data, data_sh[DATA_LEN-1:1]};

`ifdef SERIAL_MASTER_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [STALL_W-1:0] stall_cnt;
  logic               stall_state;
  logic               bit_hs;

  assign stall_state = (state == ST_HDR) || (state == ST_WSHIFT) || (state == ST_RSHIFT);
  assign bit_hs = (((state == ST_HDR) || (state == ST_WSHIFT)) && slave_ready)
                || ((state == ST_RSHIFT) && slave_valid);
  // Abort fires in the cycle that would be the TIMEOUT_CYCLES-th consecutive stall.
  assign abort = stall_state && !bit_hs && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!stall_state || bit_hs || abort) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      wr_q          <= 1'b0;
      slave_sh      <= '0;
      addr_sh       <= '0;
      burst_sh      <= '0;
      beats_left    <= '0;
      hdr_cnt       <= '0;
      bit_cnt       <= '0;
      data_sh       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q       <= req_write;
            slave_sh   <= req_slave;
            addr_sh    <= req_addr;
            burst_sh   <= (req_burst == '0) ? BURST_LEN'(1) : req_burst;
            beats_left <= (req_burst == '0) ? BURST_LEN'(1) : req_burst;
            hdr_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (approval_grant && !bus_busy) state <= ST_HDR;
        end
        ST_HDR: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (slave_ready) begin
            slave_sh <= slave_sh >> 1;
            addr_sh  <= addr_sh >> 1;
            burst_sh <= burst_sh >> 1;
            if (hdr_cnt == HDR_CW'(HDR_LEN - 1)) begin
              hdr_cnt <= '0;
              state   <= wr_q ? ST_WLOAD : ST_RSHIFT;
            end else begin
              hdr_cnt <= hdr_cnt + HDR_CW'(1);
            end
          end
        end
        ST_WLOAD: begin
          if (wdata_valid) begin
            data_sh <= wdata;
            bit_cnt <= '0;
            state   <= ST_WSHIFT;
          end
        end
        ST_WSHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (slave_ready) begin
            data_sh <= data_sh >> 1;
            if (bit_cnt == DATA_CW'(DATA_LEN - 1)) begin
              bit_cnt    <= '0;
              beats_left <= beats_left - BURST_LEN'(1);
              state      <= (beats_left == BURST_LEN'(1)) ? ST_DONE : ST_WLOAD;
            end else begin
              bit_cnt <= bit_cnt + DATA_CW'(1);
            end
          end
        end
        ST_RSHIFT: begin
          if (abort) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end else if (slave_valid) begin
            data_sh <= rx_next;
            if (bit_cnt == DATA_CW'(DATA_LEN - 1)) begin
              rdata_q       <= rx_next;
              rdata_valid_q <= 1'b1;
              bit_cnt       <= '0;
              beats_left    <= beats_left - BURST_LEN'(1);
              if (beats_left == BURST_LEN'(1)) state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + DATA_CW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = (state != ST_IDLE);
  assign req_ready   = (state == ST_IDLE);
  assign err         = abort;

  always_comb begin
    approval_request = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    master_valid     = 1'b0;
    master_ready     = 1'b0;
    wdata_ready      = 1'b0;
    tx_slave_select  = 1'b0;
    tx_address       = 1'b0;
    tx_burst_num     = 1'b0;
    tx_data          = 1'b0;
    trans_done       = 1'b0;
    case (state)
      ST_REQ: approval_request = 1'b1;
      ST_HDR: begin
        approval_request = 1'b1;
        write_en         = wr_q;
        read_en          = !wr_q;
        master_valid     = 1'b1;
        tx_slave_select  = slave_sh[0];
        tx_address       = addr_sh[0];
        tx_burst_num     = burst_sh[0];
      end
      ST_WLOAD: begin
        approval_request = 1'b1;
        write_en         = wr_q;
        read_en          = !wr_q;
        wdata_ready      = 1'b1;
      end
      ST_WSHIFT: begin
        approval_request = 1'b1;
        write_en         = wr_q;
        read_en          = !wr_q;
        master_valid     = 1'b1;
        tx_data          = data_sh[0];
      end
      ST_RSHIFT: begin
        approval_request = 1'b1;
        write_en         = wr_q;
        read_en          = !wr_q;
        master_ready     = 1'b1;
      end
      ST_DONE: trans_done = 1'b1;
      default: ;
    endcase
    // A watchdog abort closes the transaction in the same cycle, like DONE.
    if (abort) begin
      approval_request = 1'b0;
      write_en         = 1'b0;
      read_en          = 1'b0;
      master_valid     = 1'b0;
      master_ready     = 1'b0;
      tx_slave_select  = 1'b0;
      tx_address       = 1'b0;
      tx_burst_num     = 1'b0;
      tx_data          = 1'b0;
      trans_done       = 1'b1;
    end
  end

endmodule
